alu: RTL and testbench

//  32-bit integer ALU for the single-cycle/pipelined MIPS datapath, registered output stage.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_addsub.sv | 35 +++
 rtl/alu.sv | 130 +++++++++++++
 tb/tb_alu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU operation codes: the ALUFun[5:4] group selects and the sub-codes decoded inside each group.
// Pure constants, so there is no latency and no backpressure.
package alu_pkg;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  // LOGIC sub-codes, taken from ALUFun[3:0]
  localparam logic [3:0] LOG_AND    = 4'b1000;
  localparam logic [3:0] LOG_OR     = 4'b1110;
  localparam logic [3:0] LOG_XOR    = 4'b0110;
  localparam logic [3:0] LOG_NOR    = 4'b0001;
  localparam logic [3:0] LOG_PASS_A = 4'b1010;

  // SHIFT sub-codes, taken from ALUFun[1:0]
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  // CMP sub-codes, taken from ALUFun[3:1]
  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_GEZ = 3'b100;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract producing sum with Z/V/N flags; the meaning of N and V follows sign.
// Zero latency, no backpressure.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign,
  output logic [WIDTH-1:0] sum,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic             carry;
  logic             s_ovf;
  logic             borrow;

  always_comb begin
    b_eff    = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum      = full[WIDTH-1:0];
    carry    = full[WIDTH];
    // Signed overflow: both addends share a sign that the sum does not.
    s_ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    borrow   = sub & ~carry;
    zero     = (sum == '0);
    negative = sign ? sum[WIDTH-1] : borrow;
    overflow = sign ? s_ovf : (sub ? borrow : carry);
  end

endmodule

// File: rtl/alu.sv
// 32-bit MIPS ALU with a registered result (one cycle latency, no handshake, no stall).
// Define ALU_FLAGS_EN to expose the registered zero/overflow/negative flags as ports.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow,
  output logic             negative
`endif
);

  logic [1:0]       grp;
  logic             sub;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] sum;
  logic             fz;
  logic             fv;
  logic             fn;
  logic             a_neg;
  logic             a_zero;
  logic             cond;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  assign grp = ALUFun[5:4];
  // Non-ARITH groups always run A-B so the compare unit and the flags see it.
  assign sub = (grp == GRP_ARITH) ? ALUFun[0] : 1'b1;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (A),
    .b        (B),
    .sub      (sub),
    .sign     (Sign),
    .sum      (sum),
    .zero     (fz),
    .overflow (fv),
    .negative (fn)
  );

  always_comb begin
    shamt    = A[4:0];
    a_neg    = A[WIDTH-1];
    a_zero   = (A == '0);
    cond     = 1'b0;
    result_d = '0;
    unique case (grp)
      GRP_ARITH: result_d = sum;
      GRP_LOGIC: begin
        case (ALUFun[3:0])
          LOG_AND:    result_d = A & B;
          LOG_OR:     result_d = A | B;
          LOG_XOR:    result_d = A ^ B;
          LOG_NOR:    result_d = ~(A | B);
          LOG_PASS_A: result_d = A;
          default:    result_d = '0;
        endcase
      end
      GRP_SHIFT: begin
        case (ALUFun[1:0])
          SH_SLL:  result_d = B << shamt;
          SH_SRL:  result_d = B >> shamt;
          SH_SRA:  result_d = $signed(B) >>> shamt;
          default: result_d = '0;
        endcase
      end
      GRP_CMP: begin
        // Zero-compares look only at A, always as a signed value.
        case (ALUFun[3:1])
          CMP_EQ:  cond = fz;
          CMP_NEQ: cond = ~fz;
          CMP_LT:  cond = Sign ? (fn ^ fv) : fn;
          CMP_LEZ: cond = a_neg | a_zero;
          CMP_LTZ: cond = a_neg;
          CMP_GEZ: cond = ~a_neg;
          CMP_GTZ: cond = ~a_neg & ~a_zero;
          default: cond = 1'b0;
        endcase
        result_d = {{(WIDTH-1){1'b0}}, cond};
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

`ifdef ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic overflow_d, overflow_q;
  logic negative_d, negative_q;

  always_comb begin
    zero_d     = fz;
    overflow_d = fv;
    negative_d = fn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end

  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign negative = negative_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: each task drives a scenario and checks the registered result.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] result;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        overflow;
  logic        negative;
`endif

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .ALUFun (ALUFun),
    .Sign   (Sign),
    .result (result)
`ifdef ALU_FLAGS_EN
    ,
    .zero     (zero),
    .overflow (overflow),
    .negative (negative)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands on the falling edge, then sample just after the capturing edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fun, input logic sgn);
    @(negedge clk);
    A = a; B = b; ALUFun = fun; Sign = sgn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; A = 32'd5; B = 32'd5; ALUFun = 6'b000000; Sign = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_async result=%h expected=%h", result, 32'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_hold result=%h expected=%h", result, 32'h0);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({zero, overflow, negative} !== 3'b000) begin
      errors++; $display("FAIL reset_flags zvn=%b expected=000", {zero, overflow, negative});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cmp_eq();
    drive(32'hA2B042D1, 32'hA2B042D1, 6'b110011, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL cmp_eq result=%h expected=%h", result, 32'd1);
    end
    drive(32'hA2B042D1, 32'hA2B042D1, 6'b110001, 1'b0);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL cmp_neq result=%h expected=%h", result, 32'd0);
    end
    drive(32'hA2B042D1, 32'hA2B042D1, 6'b110101, 1'b0);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL cmp_lt_equal result=%h expected=%h", result, 32'd0);
    end
  endtask

  task automatic test_cmp_zero();
    // A is negative as signed; the zero-compares must ignore Sign and B.
    for (int s = 0; s < 2; s++) begin
      drive(32'hA2B042D1, 32'h0, 6'b111101, s[0]);
      checks++;
      if (result !== 32'd1) begin
        errors++; $display("FAIL cmp_lez sign=%0d result=%h expected=%h", s, result, 32'd1);
      end
      drive(32'hA2B042D1, 32'h0, 6'b111001, s[0]);
      checks++;
      if (result !== 32'd0) begin
        errors++; $display("FAIL cmp_gez sign=%0d result=%h expected=%h", s, result, 32'd0);
      end
      drive(32'hA2B042D1, 32'h0, 6'b111111, s[0]);
      checks++;
      if (result !== 32'd0) begin
        errors++; $display("FAIL cmp_gtz sign=%0d result=%h expected=%h", s, result, 32'd0);
      end
      drive(32'hA2B042D1, 32'h0, 6'b111011, s[0]);
      checks++;
      if (result !== 32'd1) begin
        errors++; $display("FAIL cmp_ltz sign=%0d result=%h expected=%h", s, result, 32'd1);
      end
    end
    // A == 0 boundary: LEZ true, GTZ false
    drive(32'h0, 32'h1234, 6'b111101, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL cmp_lez_zero result=%h expected=%h", result, 32'd1);
    end
    drive(32'h0, 32'h1234, 6'b111111, 1'b0);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL cmp_gtz_zero result=%h expected=%h", result, 32'd0);
    end
    drive(32'h00000003, 32'h0, 6'b111111, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL cmp_gtz_pos result=%h expected=%h", result, 32'd1);
    end
  endtask

  task automatic test_cmp_lt();
    drive(32'd1, 32'hFFFFFFFF, 6'b110101, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL cmp_lt_signed result=%h expected=%h", result, 32'd0);
    end
    drive(32'd1, 32'hFFFFFFFF, 6'b110101, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL cmp_lt_unsigned result=%h expected=%h", result, 32'd1);
    end
    // Signed overflow case: MIN < 1 needs N^V to be right
    drive(32'h80000000, 32'd1, 6'b110101, 1'b1);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL cmp_lt_min result=%h expected=%h", result, 32'd1);
    end
  endtask

  task automatic test_arith();
    drive(32'h7FFFFFFF, 32'd1, 6'b000000, 1'b1);
    checks++;
    if (result !== 32'h80000000) begin
      errors++; $display("FAIL add_ovf result=%h expected=%h", result, 32'h80000000);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({zero, overflow, negative} !== 3'b011) begin
      errors++; $display("FAIL add_ovf_flags zvn=%b expected=011", {zero, overflow, negative});
    end
`endif
    drive(32'd5, 32'd5, 6'b000001, 1'b1);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL sub_zero result=%h expected=%h", result, 32'd0);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({zero, overflow, negative} !== 3'b100) begin
      errors++; $display("FAIL sub_zero_flags zvn=%b expected=100", {zero, overflow, negative});
    end
`endif
    drive(32'hFFFFFFFF, 32'd2, 6'b000000, 1'b0);
    checks++;
    if (result !== 32'd1) begin
      errors++; $display("FAIL add_wrap result=%h expected=%h", result, 32'd1);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({zero, overflow, negative} !== 3'b010) begin
      errors++; $display("FAIL add_carry_flags zvn=%b expected=010", {zero, overflow, negative});
    end
`endif
    drive(32'd3, 32'd5, 6'b000001, 1'b0);
    checks++;
    if (result !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL sub_wrap result=%h expected=%h", result, 32'hFFFFFFFE);
    end
`ifdef ALU_FLAGS_EN
    checks++;
    if ({zero, overflow, negative} !== 3'b011) begin
      errors++; $display("FAIL sub_borrow_flags zvn=%b expected=011", {zero, overflow, negative});
    end
`endif
  endtask

  task automatic test_shift();
    drive(32'd4, 32'h80000001, 6'b100000, 1'b0);
    checks++;
    if (result !== 32'h00000010) begin
      errors++; $display("FAIL sll result=%h expected=%h", result, 32'h00000010);
    end
    drive(32'd4, 32'h80000001, 6'b100001, 1'b0);
    checks++;
    if (result !== 32'h08000000) begin
      errors++; $display("FAIL srl result=%h expected=%h", result, 32'h08000000);
    end
    drive(32'd4, 32'h80000001, 6'b100011, 1'b0);
    checks++;
    if (result !== 32'hF8000000) begin
      errors++; $display("FAIL sra result=%h expected=%h", result, 32'hF8000000);
    end
    // Amount 0 with junk in A[31:5] returns B unchanged
    drive(32'hFFFFFFE0, 32'h80000001, 6'b100011, 1'b0);
    checks++;
    if (result !== 32'h80000001) begin
      errors++; $display("FAIL sra_zero_amt result=%h expected=%h", result, 32'h80000001);
    end
    drive(32'd31, 32'h80000000, 6'b100011, 1'b0);
    checks++;
    if (result !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL sra_31 result=%h expected=%h", result, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_unlisted();
    drive(32'hF0F0F0F0, 32'hFF00FF00, 6'b100010, 1'b0);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL unlisted_shift result=%h expected=%h", result, 32'd0);
    end
    drive(32'hF0F0F0F0, 32'hFF00FF00, 6'b011111, 1'b0);
    checks++;
    if (result !== 32'd0) begin
      errors++; $display("FAIL unlisted_logic result=%h expected=%h", result, 32'd0);
    end
  endtask

  task automatic test_back_to_back_logic();
    logic [5:0]  fun [5] = '{6'b011000, 6'b011110, 6'b010110, 6'b010001, 6'b011010};
    logic [31:0] exp [5] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'hF0F0F0F0};
    for (int i = 0; i < 5; i++) begin
      drive(32'hF0F0F0F0, 32'hFF00FF00, fun[i], 1'b0);
      checks++;
      if (result !== exp[i]) begin
        errors++; $display("FAIL logic_%0d result=%h expected=%h", i, result, exp[i]);
      end
    end
    // Reset lands mid-cycle while the last result is still held
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_midstream result=%h expected=%h", result, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cmp_eq();
    test_cmp_zero();
    test_cmp_lt();
    test_arith();
    test_shift();
    test_unlisted();
    test_back_to_back_logic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
